// File: rtl/pattern_stream_controller.sv
// -----------------------------------------------------------------------------
// pattern_stream_controller
//
// AXI-Stream pattern source for one RFSoC DAC tile stream input. A host-loaded
// register-array pattern memory of DEPTH beats is played in continuous,
// one-shot or counted-repeat mode. tready backpressure is honoured, tlast marks
// the final beat of each pattern pass, and busy/done report to the control
// plane.
//
// Ports:
//   clk, rst              stream/control clock, asynchronous active-high reset
//   cfg_wr_en/addr/data   pattern memory write port (sample 0 in the low bits)
//   mode                  0=off, 1=continuous, 2=one-shot, 3=counted repeat
//   last_addr             index of the final beat of the pattern
//   repeat_count          number of passes in counted-repeat mode (0 acts as 1)
//   start, stop           single-cycle start / graceful stop requests
//   m_axis_*              AXI-Stream master (tdata, tvalid, tready, tlast)
//   busy                  high while playing
//   done                  one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module pattern_stream_controller #(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int SAMPLES_PER_BEAT = 16,
    parameter int DATA_WIDTH       = SAMPLE_WIDTH * SAMPLES_PER_BEAT,
    parameter int DEPTH            = 16,
    parameter int ADDR_WIDTH       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0] cfg_wr_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wr_data,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic [15:0]           repeat_count,
    input  logic                  start,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_COUNTED = 2'd3;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] cap_last;
    logic [1:0]            cap_mode;
    logic [15:0]           cap_repeat;
    logic [15:0]           pass_cnt;
    logic                  stop_req;

    logic [ADDR_WIDTH-1:0] next_ptr;
    logic                  handshake;
    logic                  pass_end;
    logic                  end_play;

    always_comb begin
        next_ptr  = (ptr == cap_last) ? '0 : ptr + ADDR_WIDTH'(1);
        handshake = m_axis_tvalid && m_axis_tready;
        pass_end  = handshake && m_axis_tlast;
        // A stop arriving on the same edge as the closing tlast handshake
        // still ends playback there, hence the raw stop term.
        end_play  = pass_end &&
                    ((cap_mode == MODE_ONESHOT) ||
                     ((cap_mode == MODE_COUNTED) && (pass_cnt + 16'd1 == cap_repeat)) ||
                     stop_req || stop);
    end

    // Pattern memory: single write port, accepted in any state.
    // NOTE: the memory is cleared by the asynchronous reset, so a reset really
    // does lose the pattern; this keeps it a flop array rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (cfg_wr_en) begin
            mem[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // Playback FSM with registered stream outputs. Because mem is updated with
    // a non-blocking write, a load from the address being written on the same
    // edge sees the old word.
    // NOTE: all state here uses non-blocking assignments so every read in this
    // block sees the pre-edge value, and later assignments override earlier ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            cap_last      <= '0;
            cap_mode      <= MODE_OFF;
            cap_repeat    <= 16'd1;
            pass_cnt      <= '0;
            stop_req      <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (mode != MODE_OFF)) begin
                        state         <= RUN;
                        cap_mode      <= mode;
                        cap_last      <= last_addr;
                        cap_repeat    <= (repeat_count == 16'd0) ? 16'd1 : repeat_count;
                        ptr           <= '0;
                        pass_cnt      <= '0;
                        stop_req      <= 1'b0;
                        m_axis_tdata  <= mem[0];
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (last_addr == '0);
                        busy          <= 1'b1;
                    end
                end

                RUN: begin
                    if (stop) begin
                        stop_req <= 1'b1;
                    end
                    if (handshake) begin
                        if (end_play) begin
                            state         <= IDLE;
                            ptr           <= '0;
                            pass_cnt      <= '0;
                            stop_req      <= 1'b0;
                            m_axis_tdata  <= '0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            ptr          <= next_ptr;
                            m_axis_tdata <= mem[next_ptr];
                            m_axis_tlast <= (next_ptr == cap_last);
                            if (pass_end && (cap_mode == MODE_COUNTED)) begin
                                pass_cnt <= pass_cnt + 16'd1;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_stream_controller.sv
// -----------------------------------------------------------------------------
// tb_pattern_stream_controller
//
// Self-checking bench for pattern_stream_controller. The reference model keeps
// a copy of the pattern memory and expands each playback into a queue of
// expected beats (pattern order, passes, tlast positions); every accepted beat
// is popped from that queue and compared. Inputs are driven and outputs
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pattern_stream_controller;

    localparam int DW = 256;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          cfg_wr_en;
    logic [AW-1:0] cfg_wr_addr;
    logic [DW-1:0] cfg_wr_data;
    logic [1:0]    mode;
    logic [AW-1:0] last_addr;
    logic [15:0]   repeat_count;
    logic          start;
    logic          stop;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;

    pattern_stream_controller dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_wr_addr   (cfg_wr_addr),
        .cfg_wr_data   (cfg_wr_data),
        .mode          (mode),
        .last_addr     (last_addr),
        .repeat_count  (repeat_count),
        .start         (start),
        .stop          (stop),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    int            vectors     = 0;
    int            miscompares = 0;

    function automatic logic [DW-1:0] rep(input logic [15:0] s);
        return {16{s}};
    endfunction

    // Expected stream for a playback: `passes` walks over beats 0..la.
    task automatic build_queue(input int la, input int passes);
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k <= la; k++) begin
                beat_t b;
                b.data = model_mem[k];
                b.last = (k == la);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic write_mem(input int a, input logic [DW-1:0] d);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = AW'(a);
        cfg_wr_data = d;
        @(negedge clk);
        cfg_wr_en   = 1'b0;
        model_mem[a] = d;
    endtask

    // Pulse start; afterwards scramble the config inputs, which must be ignored.
    task automatic start_play(input logic [1:0] m, input int la, input int rc);
        mode         = m;
        last_addr    = AW'(la);
        repeat_count = 16'(rc);
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        mode         = 2'($urandom_range(0, 3));
        last_addr    = AW'($urandom_range(0, DEPTH - 1));
        repeat_count = 16'($urandom_range(0, 9));
    endtask

    // Consume exp_q beat by beat, then expect the done pulse and an idle bus.
    // stop_at: pulse stop once when that many beats remain (0 = never).
    // wr_cyc: cycle index at which to write wr_data to wr_addr (-1 = never).
    task automatic drain(input string name, input bit rand_ready, input int stop_at,
                         input int wr_cyc, input int wr_addr, input logic [DW-1:0] wr_data,
                         input int budget, output int cycles);
        bit stop_sent = 1'b0;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < budget) begin
            vectors++;
            if (m_axis_tvalid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s status cyc %0d: tvalid=%b busy=%b done=%b, want 1 1 0",
                         name, cycles, m_axis_tvalid, busy, done);
            end
            vectors++;
            if (m_axis_tdata !== exp_q[0].data || m_axis_tlast !== exp_q[0].last) begin
                miscompares++;
                $display("FAIL %s beat cyc %0d: got %h last=%b, want %h last=%b",
                         name, cycles, m_axis_tdata, m_axis_tlast, exp_q[0].data, exp_q[0].last);
            end
            if (!stop_sent && stop_at > 0 && exp_q.size() == stop_at) begin
                stop      = 1'b1;
                stop_sent = 1'b1;
            end else begin
                stop = 1'b0;
            end
            if (cycles == wr_cyc) begin
                cfg_wr_en   = 1'b1;
                cfg_wr_addr = AW'(wr_addr);
                cfg_wr_data = wr_data;
                model_mem[wr_addr] = wr_data;
            end else begin
                cfg_wr_en = 1'b0;
            end
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tready) void'(exp_q.pop_front());
            @(negedge clk);
            cycles++;
        end
        stop      = 1'b0;
        cfg_wr_en = 1'b0;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL %s timeout: %0d beats outstanding after %0d cycles",
                     name, exp_q.size(), cycles);
            exp_q.delete();
        end
        vectors++;
        if (done !== 1'b1 || m_axis_tvalid !== 1'b0 || busy !== 1'b0 ||
            m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
            miscompares++;
            $display("FAIL %s end: done=%b tvalid=%b busy=%b tlast=%b tdata=%h, want 1 0 0 0 0",
                     name, done, m_axis_tvalid, busy, m_axis_tlast, m_axis_tdata);
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after end: done=%b tvalid=%b, want 0 0", name, done, m_axis_tvalid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset outputs: tvalid=%b tdata=%h tlast=%b busy=%b done=%b, want all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // start with mode 0 must be ignored
        mode  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_mode0: tvalid=%b busy=%b, want 0 0", m_axis_tvalid, busy);
        end
    endtask

    task automatic test_one_shot();
        int cyc;
        for (int k = 0; k < 4; k++) write_mem(k, rep(16'(k + 1)));
        build_queue(3, 1);
        start_play(2'd2, 3, 0);
        drain("one_shot", 1'b0, 0, -1, 0, '0, 20, cyc);
        vectors++;
        if (cyc !== 4) begin
            miscompares++;
            $display("FAIL one_shot cycles: got %0d, want 4", cyc);
        end
    endtask

    task automatic test_counted();
        int cyc;
        build_queue(3, 3);
        start_play(2'd3, 3, 3);
        drain("counted_3", 1'b0, 0, -1, 0, '0, 40, cyc);
        vectors++;
        if (cyc !== 12) begin
            miscompares++;
            $display("FAIL counted_3 cycles: got %0d, want 12", cyc);
        end
        build_queue(3, 1);
        start_play(2'd3, 3, 0);
        drain("counted_0", 1'b0, 0, -1, 0, '0, 20, cyc);
        vectors++;
        if (cyc !== 4) begin
            miscompares++;
            $display("FAIL counted_0 cycles: got %0d, want 4", cyc);
        end
        // single-beat pattern: every beat is mem[0] with tlast
        build_queue(0, 2);
        start_play(2'd3, 0, 2);
        drain("last_addr_0", 1'b1, 0, -1, 0, '0, 200, cyc);
    endtask

    task automatic test_continuous_random();
        int cyc;
        build_queue(3, 250);
        // stop arrives while mem[1] (beat 2 of the final pass) is presented
        start_play(2'd1, 3, 0);
        drain("continuous_rand", 1'b1, 3, -1, 0, '0, 20000, cyc);
    endtask

    task automatic test_write_collision();
        int cyc;
        beat_t b;
        build_queue(3, 1);
        for (int k = 0; k < 4; k++) begin
            b.data = (k == 2) ? {DW{1'b1}} : model_mem[k];
            b.last = (k == 3);
            exp_q.push_back(b);
        end
        // Write mem[2] on the edge that loads mem[2]; stop on the second tlast.
        start_play(2'd1, 3, 0);
        drain("write_collision", 1'b0, 1, 1, 2, {DW{1'b1}}, 40, cyc);
    endtask

    task automatic test_async_reset();
        int cyc;
        m_axis_tready = 1'b1;
        start_play(2'd1, 3, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: tvalid=%b busy=%b, want 0 0", m_axis_tvalid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
        @(negedge clk);
        build_queue(3, 1);
        start_play(2'd2, 3, 0);
        drain("post_reset_zero", 1'b0, 0, -1, 0, '0, 20, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        cfg_wr_en     = 1'b0;
        cfg_wr_addr   = '0;
        cfg_wr_data   = '0;
        mode          = 2'd0;
        last_addr     = '0;
        repeat_count  = '0;
        start         = 1'b0;
        stop          = 1'b0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;

        test_reset();
        test_one_shot();
        test_counted();
        test_continuous_random();
        test_write_collision();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_stream_controller.md
Name: pattern_stream_controller

Overview:
- Parametrised AXI-Stream pattern source feeding one RFSoC DAC tile's stream input; successor to the fixed-constant dummy source used for hardware bring-up.
- Plays a host-loaded pattern memory of DEPTH beats (SAMPLES_PER_BEAT samples of SAMPLE_WIDTH bits per beat) in continuous, one-shot or counted-repeat mode.
- Honours tready backpressure, marks pattern boundaries with tlast, and reports busy/done to the control plane.

Parameters:
- SAMPLE_WIDTH, 16, bits per DAC sample
- SAMPLES_PER_BEAT, 16, samples packed per stream beat
- DATA_WIDTH, SAMPLE_WIDTH*SAMPLES_PER_BEAT (256), stream data width
- DEPTH, 16, pattern memory depth in beats (power of two, ≥2)
- ADDR_WIDTH, $clog2(DEPTH), pattern address width

Ports:
- clk  in  1  stream and control clock
- rst  in  1  asynchronous, active-high reset
- cfg_wr_en  in  1  pattern memory write strobe
- cfg_wr_addr  in  ADDR_WIDTH  write address
- cfg_wr_data  in  DATA_WIDTH  write data; sample 0 in bits [SAMPLE_WIDTH-1:0]
- mode  in  2  0=off, 1=continuous loop, 2=one-shot, 3=counted repeat
- last_addr  in  ADDR_WIDTH  index of final beat of the pattern
- repeat_count  in  16  number of passes in mode 3
- start  in  1  single-cycle start request
- stop  in  1  single-cycle graceful stop request
- m_axis_tdata  out  DATA_WIDTH  sample beat
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  high on the beat at last_addr
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when playback ends

Behaviour:
- Reset, applied asynchronously: all pattern memory words = 0; state IDLE; tdata=0, tvalid=0, tlast=0, busy=0, done=0; address pointer and pass counter = 0.
- Pattern memory is a register array with one write port:
  - Writes accepted in any state.
  - A write to the address being loaded into the output register on the same edge is not seen by that load; the old word goes out and the new word is visible from the next load.
- States: IDLE, RUN.
- IDLE → RUN: start=1 and mode≠0.
  - On that edge, capture mode, last_addr and repeat_count (0 is treated as 1).
  - Load mem[0] into tdata. tvalid=1 and busy=1 from the next cycle (latency 1).
  - start with mode=0 is ignored.
- Configuration inputs are ignored while in RUN. start in RUN is ignored.
- AXI-Stream rules:
  - While tvalid=1 and tready=0, tdata and tlast hold.
  - On handshake (tvalid&&tready), the next beat loads on the same edge, so back-to-back beats have no bubbles.
- Pointer advance: ptr increments on each handshake. When ptr==last_addr it wraps to 0. tlast = (ptr==last_addr).
- Pass end (handshake with tlast=1):
  - mode 1: continue looping.
  - mode 2: end.
  - mode 3: pass counter increments; end when it reaches repeat_count.
- stop: sets a sticky stop_req while in RUN, ignored in IDLE. Playback ends at the next tlast handshake. stop on the same edge as that handshake also ends playback at that handshake.
- End of playback, on the ending edge:
  - tvalid→0, tdata→0, tlast→0, busy→0, state→IDLE.
  - done=1 for exactly the following cycle.
  - Pass counter and stop_req clear.
- last_addr=0: every beat is mem[0] with tlast=1.
- start on the same cycle as done: accepted (state is IDLE).
- Reset mid-playback: tvalid drops immediately (asynchronous) and memory contents are lost.

Test Plan:
- Load mem[k]={16{k+1 in 16 bits}} for k=0..3; mode=2, last_addr=3, tready=1, pulse start → beats 0x0001…,0x0002…,0x0003…,0x0004… on 4 consecutive cycles starting 1 cycle after start; tlast only on the 4th; done pulses on the cycle after the 4th beat; tvalid=0 afterwards.
- Same pattern, mode=3, repeat_count=3 → 12 beats, tlast on beats 4, 8 and 12, single done; repeat_count=0 → exactly 4 beats.
- mode=1, random tready (50%) → tdata/tlast stable whenever tvalid&&!tready; accepted beats follow 1,2,3,4,1,2,… with no skips or duplicates over 1000 beats.
- mode=1, stop pulsed while beat 2 is presented → beats 2,3,4 are still accepted and playback ends after beat 4 (tlast); done=1 one cycle later; no beat 1 follows.
- During mode 1 playback, write mem[2]=0xFFFF… on the same edge beat 2 loads → this pass carries the old value; the next pass carries 0xFFFF….
- Assert rst asynchronously mid-beat → tvalid=0 and busy=0 without waiting for a clock edge; after release, a one-shot start streams all-zero beats.
